// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem request tracking,
// and the IF/ID register that feeds decode (bubbles are NOP_INSTR with valid_out=0).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  fetch_sel,
    input  logic        nop_in,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [6:0]  opcode_out
);

    localparam logic [1:0] FETCH_SEL_PC     = 2'b00;
    localparam logic [1:0] FETCH_SEL_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        KILL = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [29:0] pc_word;
    logic [29:0] pc_next;
    logic        deliver;
    logic        sel_pc;
    logic        sel_branch;
    logic        unused_bt_lsbs;

    // PC is kept word-aligned by construction, so the low target bits never matter.
    assign unused_bt_lsbs = ^branch_target[1:0];

    assign sel_pc     = (fetch_sel == FETCH_SEL_PC);
    assign sel_branch = (fetch_sel == FETCH_SEL_BRANCH);
    assign imem_req   = (state == IDLE) && sel_pc && !rst;
    assign imem_addr  = {pc_word, 2'b00};
    assign opcode_out = instr_out[6:0];

    always_comb begin
        state_next = state;
        pc_next    = pc_word;
        deliver    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_pc) begin
                    state_next = WAIT;
                end else if (sel_branch) begin
                    pc_next = branch_target[31:2];
                end
            end
            WAIT: begin
                if (sel_branch) begin
                    pc_next    = branch_target[31:2];
                    state_next = imem_valid ? IDLE : KILL;
                end else if (imem_valid) begin
                    pc_next    = pc_word + 30'd1;
                    state_next = IDLE;
                    deliver    = 1'b1;
                end
            end
            KILL: begin
                if (sel_branch) begin
                    pc_next = branch_target[31:2];
                end
                if (imem_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_word   <= RESET_PC[31:2];
            instr_out <= NOP_INSTR;
            pc_out    <= 32'h0000_0000;
            valid_out <= 1'b0;
        end else begin
            state   <= state_next;
            pc_word <= pc_next;
            // A squashed word still advances the PC but leaves pc_out on the last real instruction.
            if (deliver && !nop_in) begin
                instr_out <= imem_rdata;
                pc_out    <= {pc_word, 2'b00};
                valid_out <= 1'b1;
            end else begin
                instr_out <= NOP_INSTR;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected deliveries go into a queue that a negedge
// monitor drains whenever valid_out is high; address/bubble checks are inline.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fetch_sel;
    logic        nop_in;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [6:0]  opcode_out;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_sel(fetch_sel), .nop_in(nop_in),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr_out(instr_out),
        .pc_out(pc_out), .valid_out(valid_out), .opcode_out(opcode_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, {31'd0, valid_out}, 32'd0);
        chk({name, "_instr"}, instr_out, NOP);
    endtask

    task automatic drive(input logic [1:0] sel, input logic nop, input logic [31:0] bt,
                         input logic iv, input logic [31:0] rd);
        fetch_sel     = sel;
        nop_in        = nop;
        branch_target = bt;
        imem_valid    = iv;
        imem_rdata    = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc);
        exp_q.push_back({instr, pc});
    endtask

    // Monitor: every delivered word must match the oldest expected entry.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_delivery: got instr %h pc %h, expected no delivery", instr_out, pc_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("mon_instr", instr_out, e[63:32]);
                chk("mon_pc", pc_out, e[31:0]);
                chk("mon_opcode", {25'd0, opcode_out}, {25'd0, e[38:32]});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("req_in_reset", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;

        // Sequential fetches at 0 and 4 with latency 1
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq0_req", {31'd0, imem_req}, 32'd1);
        chk("seq0_addr", imem_addr, 32'h0);
        tick();
        drive(2'b00, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
        expect_word(32'h0050_0093, 32'h0);
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_addr", imem_addr, 32'h0);
        tick();
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk_bubble("after_deliver");
        drive(2'b00, 1'b0, 32'h0, 1'b1, 32'h00a0_0113);
        expect_word(32'h00a0_0113, 32'h4);
        tick();

        // Branch while waiting: late word at 0x8 is dropped
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq2_addr", imem_addr, 32'h8);
        tick();
        drive(2'b10, 1'b0, 32'h40, 1'b0, 32'h0);
        tick();
        chk_bubble("kill0");
        chk("kill_addr", imem_addr, 32'h40);
        drive(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(2'b01, 1'b0, 32'h0, 1'b1, 32'hdead_beef);
        tick();
        chk_bubble("kill_drop");
        drive(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("post_kill_addr", imem_addr, 32'h40);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        tick();

        // Branch in IDLE to 0xC, then squash the returned word with nop_in
        drive(2'b10, 1'b0, 32'h0000_000C, 1'b0, 32'h0);
        tick();
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("idle_br_addr", imem_addr, 32'hC);
        chk("idle_br_req", {31'd0, imem_req}, 32'd1);
        tick();
        drive(2'b00, 1'b1, 32'h0, 1'b1, 32'h1234_5678);
        tick();
        chk_bubble("nop_in");
        chk("nop_in_pc_hold", pc_out, 32'h4);
        chk("nop_in_addr", imem_addr, 32'h10);

        // Branch coincident with imem_valid at 0x10
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(2'b10, 1'b0, 32'h40, 1'b1, 32'h0bad_f00d);
        tick();
        chk_bubble("coinc");
        chk("coinc_addr", imem_addr, 32'h40);
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("coinc_idle_req", {31'd0, imem_req}, 32'd1);

        // Hold for three cycles at 0x20, then reserved select behaves as hold
        drive(2'b10, 1'b0, 32'h20, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive((i == 3) ? 2'b11 : 2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("hold_req_n", {31'd0, imem_req}, 32'd0);
            tick();
            chk("hold_addr", imem_addr, 32'h20);
            chk_bubble("hold");
        end

        // PC wrap and target alignment
        drive(2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        tick();
        chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(2'b00, 1'b0, 32'h0, 1'b1, 32'h0010_0073);
        expect_word(32'h0010_0073, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        drive(2'b10, 1'b0, 32'h0000_0107, 1'b0, 32'h0);
        tick();
        chk("align_addr", imem_addr, 32'h104);

        // Branch again while in KILL; last target wins
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(2'b10, 1'b0, 32'h200, 1'b0, 32'h0);
        tick();
        drive(2'b10, 1'b0, 32'h300, 1'b0, 32'h0);
        tick();
        chk("kill_br_addr", imem_addr, 32'h300);
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("kill_req", {31'd0, imem_req}, 32'd0);
        drive(2'b01, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        tick();
        chk_bubble("kill_br_drop");
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("kill_exit_req", {31'd0, imem_req}, 32'd1);
        chk("kill_exit_addr", imem_addr, 32'h300);
        tick();
        drive(2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0293);
        expect_word(32'h0000_0293, 32'h300);
        tick();
        chk("post300_addr", imem_addr, 32'h304);

        // Reset with a request outstanding; stray imem_valid afterwards is ignored
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        drive(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        chk("mid_rst_pc_out", pc_out, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        drive(2'b01, 1'b0, 32'h0, 1'b1, 32'hcafe_babe);
        tick();
        chk_bubble("post_rst_valid");
        drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        drive(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
